// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, segment codes
// (gfedcba, active-low), conversion step count and one double-dabble step.
// Purely declarative; no clocked logic lives here.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // One shift per input bit of a 5-bit score.
  localparam int STEPS = 5;

  // One double-dabble step on {tens[1:0], ones[3:0], bin[4:0]}. The tens
  // nibble never exceeds 3 for a 5-bit input, so only the ones digit needs
  // the +3 correction before the shift.
  function automatic logic [10:0] dd_step(input logic [5:0] bcd, input logic [4:0] bin);
    logic [3:0]  ones;
    logic [10:0] tmp;
    ones = (bcd[3:0] >= 4'd5) ? (bcd[3:0] + 4'd3) : bcd[3:0];
    tmp  = {bcd[5:4], ones, bin};
    return {tmp[9:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (gfedcba), with blank enable.
// Latency: combinational. Backpressure: none.
// Non-decimal codes (10-15) also drive a blank pattern.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Table lookup; blanking overrides the digit.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Player/dealer 5-bit scores -> four active-low 7-seg digits; optional blink via HEX_BLINK_EN.
// Latency: load accepted at edge k, hex outputs update and busy drops at edge k+6.
// Backpressure: load is ignored while busy=1; captured scores are never disturbed.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned BLINK_HALF_PERIOD = 24999999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] player_score,
  input  logic [4:0] dealer_score,
  input  logic       blink,
  output logic       busy,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  state_t      state_q;
  logic        busy_q;
  logic [2:0]  step_q;
  logic [4:0]  p_bin_q, d_bin_q;
  logic [5:0]  p_bcd_q, d_bcd_q;
  logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q;
  logic [10:0] p_dd_d, d_dd_d;
  logic [6:0]  p_ones_seg, p_tens_seg, d_ones_seg, d_tens_seg;
  logic        blank_mask;

  // Next double-dabble value for both scores, consumed in CONVERT.
  always_comb begin
    p_dd_d = dd_step(p_bcd_q, p_bin_q);
    d_dd_d = dd_step(d_bcd_q, d_bin_q);
  end

  // Ones digits always show; tens digits blank when zero.
  seg7_decode u_p_ones (.digit_i(p_bcd_q[3:0]),         .blank_i(1'b0),               .seg_o(p_ones_seg));
  seg7_decode u_p_tens (.digit_i({2'b00, p_bcd_q[5:4]}), .blank_i(p_bcd_q[5:4] == 2'd0), .seg_o(p_tens_seg));
  seg7_decode u_d_ones (.digit_i(d_bcd_q[3:0]),         .blank_i(1'b0),               .seg_o(d_ones_seg));
  seg7_decode u_d_tens (.digit_i({2'b00, d_bcd_q[5:4]}), .blank_i(d_bcd_q[5:4] == 2'd0), .seg_o(d_tens_seg));

  // Control FSM: capture on load, five conversion steps, then register the digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      step_q  <= 3'd0;
      p_bin_q <= 5'd0;
      d_bin_q <= 5'd0;
      p_bcd_q <= 6'd0;
      d_bcd_q <= 6'd0;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex3_q  <= SEG_BLANK;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            p_bin_q <= player_score;
            d_bin_q <= dealer_score;
            p_bcd_q <= 6'd0;
            d_bcd_q <= 6'd0;
            step_q  <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          {p_bcd_q, p_bin_q} <= p_dd_d;
          {d_bcd_q, d_bin_q} <= d_dd_d;
          step_q <= step_q + 3'd1;
          if (step_q == 3'(STEPS - 1)) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          hex0_q  <= p_ones_seg;
          hex1_q  <= p_tens_seg;
          hex2_q  <= d_ones_seg;
          hex3_q  <= d_tens_seg;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef HEX_BLINK_EN
  localparam int unsigned CW = (BLINK_HALF_PERIOD > 0) ? $clog2(BLINK_HALF_PERIOD + 1) : 1;
  localparam logic [CW-1:0] HALF_C = CW'(BLINK_HALF_PERIOD);

  logic [CW-1:0] blink_cnt_q;
  logic          phase_q;

  // Half-period timer; dropping blink restarts it so the next blink opens visible.
  always_ff @(posedge clk) begin
    if (reset || !blink) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == HALF_C) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end

  assign blank_mask = blink & phase_q;
`else
  localparam int unsigned unused_half_period = BLINK_HALF_PERIOD;
  logic unused_blink;
  assign unused_blink = blink;
  assign blank_mask   = 1'b0;
`endif

  assign busy = busy_q;
  assign hex0 = blank_mask ? SEG_BLANK : hex0_q;
  assign hex1 = blank_mask ? SEG_BLANK : hex1_q;
  assign hex2 = blank_mask ? SEG_BLANK : hex2_q;
  assign hex3 = blank_mask ? SEG_BLANK : hex3_q;

endmodule
